// File: rtl/aes_128_in_loader.sv
// Packs 4x32-bit words into 128-bit blocks, buffers two, issues one aes_in_en per block (push->issue 1 cycle).
// s_ready drops whenever both slots are full; one block in flight, HOLD waits out core restart.
module aes_128_in_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic         clk,
  input  logic         kill,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         aes_in_en,
  output logic [127:0] aes_data,
  input  logic         aes_idle,
  input  logic         aes_out_en,
  output logic [1:0]   level,
  output logic         frame_err,
  output logic         timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_HOLD} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t              state_q;
  logic [1:0]          wc_q, wc_d;
  logic [95:0]         part_q, part_d;
  logic [1:0][127:0]   mem_q, mem_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          level_q, level_d;
  logic                frame_err_q, frame_err_d;
  logic                aes_in_en_q;
  logic [127:0]        aes_data_q;
  logic                timeout_err_q;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic [1:0]          hold_cnt_q;
  logic                accept, push, pop;

  assign s_ready = (level_q != 2'd2);
  assign accept  = s_valid & s_ready;
  assign pop     = (state_q == ST_ISSUE);

  always_comb begin
    wc_d        = wc_q;
    part_d      = part_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (accept) begin
      if (wc_q == 2'd3) begin
        push        = s_last;
        frame_err_d = ~s_last;
        wc_d        = 2'd0;
      end else if (s_last) begin
        frame_err_d = 1'b1;
        wc_d        = 2'd0;
      end else begin
        // Shift left so the first word ends up in the top slice.
        part_d = {part_q[63:0], s_data};
        wc_d   = wc_q + 2'd1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {part_q, s_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wc_q        <= 2'd0;
      part_q      <= '0;
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      level_q     <= 2'd0;
      frame_err_q <= 1'b0;
    end else begin
      wc_q        <= wc_d;
      part_q      <= part_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Saturating increment; "reaching the limit" means the next count equals it.
  always_comb begin
    tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q       <= ST_IDLE;
      aes_in_en_q   <= 1'b0;
      aes_data_q    <= '0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= 8'd0;
      hold_cnt_q    <= 2'd0;
    end else begin
      aes_in_en_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level_q != 2'd0 && !aes_idle) begin
            state_q     <= ST_ISSUE;
            aes_in_en_q <= 1'b1;
            aes_data_q  <= mem_q[rd_ptr_q];
          end
        end
        ST_ISSUE: begin
          state_q   <= ST_BUSY;
          tmo_cnt_q <= 8'd0;
        end
        ST_BUSY: begin
          if (aes_out_en) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= 2'd0;
          end else if (tmo_cnt_d == TMO_LIMIT) begin
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == 2'd2) begin
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign aes_in_en   = aes_in_en_q;
  assign aes_data    = aes_data_q;
  assign level       = level_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_128_in_loader.sv
// Randomised + directed bench for aes_128_in_loader with a frame-level reference model and scoreboard.
module tb_aes_128_in_loader;
  localparam int TMO = 63;

  logic         clk = 1'b0;
  logic         kill;
  logic [31:0]  s_data;
  logic         s_valid, s_last, s_ready;
  logic         aes_in_en;
  logic [127:0] aes_data;
  logic         aes_idle, aes_out_en;
  logic [1:0]   level;
  logic         frame_err, timeout_err;

  always #5 clk = ~clk;

  aes_128_in_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .kill(kill), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .aes_in_en(aes_in_en), .aes_data(aes_data), .aes_idle(aes_idle),
    .aes_out_en(aes_out_en), .level(level), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: frames of words, queue of expected blocks and pulse cycles.
  logic [31:0]  words[$];
  logic [127:0] exp_q[$];
  int           frame_q[$];
  int           tmo_q[$];
  int           n_push = 0, n_pop = 0, n_issue = 0, push_cyc = -1;

  task automatic model_accept(input logic [31:0] d, input bit last);
    if (words.size() == 3) begin
      if (last) begin
        exp_q.push_back({words[0], words[1], words[2], d});
        n_push++;
        push_cyc = cyc;
      end else begin
        frame_q.push_back(cyc);
      end
      words.delete();
    end else if (last) begin
      frame_q.push_back(cyc);
      words.delete();
    end else begin
      words.push_back(d);
    end
  endtask

  task automatic model_kill();
    words.delete(); exp_q.delete(); frame_q.delete(); tmo_q.delete();
    n_push = 0; n_pop = 0;
  endtask

  // Core model.
  bit respond = 1'b1, rand_delay = 1'b0, pending = 1'b0, core_busy = 1'b0, idle_force = 1'b0;
  bit out_seen = 1'b0;
  int core_delay = 41, out_at = 0, last_out_cyc = -100;
  assign aes_idle = core_busy | idle_force;

  initial begin
    aes_out_en = 1'b0;
    forever begin
      @(negedge clk);
      aes_out_en = 1'b0;
      if (kill) begin
        pending = 1'b0; core_busy = 1'b0;
      end else begin
        if (pending && cyc == out_at) begin
          aes_out_en = 1'b1; pending = 1'b0; core_busy = 1'b0;
          last_out_cyc = cyc; out_seen = 1'b1;
        end
        if (aes_in_en && respond) begin
          pending = 1'b1; core_busy = 1'b1;
          out_at = cyc + (rand_delay ? int'($urandom_range(5, 60)) : core_delay);
        end
      end
    end
  end

  // Monitor / scoreboard.
  int exp_issue = -1;
  bit prev_in_en = 1'b0;
  logic [127:0] last_blk = '0;

  always @(negedge clk) begin
    if (kill) begin
      prev_in_en = 1'b0; exp_issue = -1; last_blk = '0;
    end else begin
      chk("level", longint'(level), longint'(n_push - n_pop));
      chk("s_ready", longint'(s_ready), longint'((n_push - n_pop) != 2));
      if (exp_issue == cyc) chk("issue_gap", longint'(aes_in_en), 1);
      if (aes_in_en) begin
        n_issue++;
        chk("in_en_back_to_back", longint'(prev_in_en), 0);
        if (out_seen) chk("min_gap_after_out_en", longint'(cyc >= last_out_cyc + 5), 1);
        chk("issue_expected", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          last_blk = exp_q.pop_front();
          chkw("aes_data", aes_data, last_blk);
          n_pop++;
        end
        if (!respond) tmo_q.push_back(cyc + TMO + 1);
      end else begin
        chkw("aes_data_hold", aes_data, last_blk);
      end
      if (frame_err) begin
        chk("frame_err_expected", longint'(frame_q.size() != 0), 1);
        if (frame_q.size() != 0) chk("frame_err_cycle", cyc, frame_q.pop_front());
      end
      if (timeout_err) begin
        chk("timeout_expected", longint'(tmo_q.size() != 0), 1);
        if (tmo_q.size() != 0) chk("timeout_cycle", cyc, tmo_q.pop_front());
        if (n_push - n_pop > 0 && !idle_force) exp_issue = cyc + 1;
      end
      if (out_seen && cyc == last_out_cyc + 4 && n_push - n_pop > 0 && !idle_force)
        exp_issue = cyc + 1;
      prev_in_en = aes_in_en;
    end
  end

  // Stimulus helpers; all start and end just after a rising edge.
  task automatic send_word(input logic [31:0] d, input bit last);
    int waited = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 400) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) chk("s_ready_wait_expired", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (waited < 400) model_accept(d, last);
  endtask

  task automatic send_block(input logic [127:0] b);
    send_word(b[127:96], 1'b0);
    send_word(b[95:64], 1'b0);
    send_word(b[63:32], 1'b0);
    send_word(b[31:0], 1'b1);
  endtask

  task automatic wait_issue(output int at);
    at = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (aes_in_en) begin
        at = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pending || core_busy || tmo_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (6) begin @(posedge clk); #1; end
    chk("drain_exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at, r;
    logic [127:0] blk;
    kill = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("rst_in_en", longint'(aes_in_en), 0);
    chkw("rst_aes_data", aes_data, '0);
    chk("rst_frame_err", longint'(frame_err), 0);
    chk("rst_timeout_err", longint'(timeout_err), 0);
    chk("rst_level", longint'(level), 0);
    chk("rst_s_ready", longint'(s_ready), 1);
    @(posedge clk); #1;

    // Single block with fixed words.
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    wait_issue(at);
    chk("single_latency", at, push_cyc + 1);
    chkw("single_data", aes_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    drain();

    // Back-pressure: three blocks while the core is held busy.
    idle_force = 1'b1;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block({$urandom, $urandom, $urandom, $urandom});
      end
      begin
        for (int n = 0; n < 200 && level != 2'd2; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("bp_stall_s_ready", longint'(s_ready), 0);
        @(posedge clk); #1;
        idle_force = 1'b0;
      end
    join
    drain();

    // Framing: early s_last, then a good block, then a missing s_last, then a good block.
    send_word(32'hA0A0A0A0, 1'b0);
    send_word(32'hA1A1A1A1, 1'b1);
    send_block(128'h11111111_22222222_33333333_44444444);
    for (int w = 0; w < 4; w++) send_word(32'hB0B0B0B0 + w, 1'b0);
    send_block(128'h55555555_66666666_77777777_88888888);
    drain();
    chk("frame_q_empty", frame_q.size(), 0);

    // Timeout: core never answers; second buffered block issues afterwards.
    respond = 1'b0;
    idle_force = 1'b1;
    send_block({$urandom, $urandom, $urandom, $urandom});
    send_block({$urandom, $urandom, $urandom, $urandom});
    idle_force = 1'b0;
    drain();
    chk("tmo_q_empty", tmo_q.size(), 0);
    respond = 1'b1;

    // Kill during BUSY with one block buffered and two words assembled.
    send_block({$urandom, $urandom, $urandom, $urandom});
    wait_issue(at);
    send_block({$urandom, $urandom, $urandom, $urandom});
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'hFEEDFACE, 1'b0);
    kill = 1'b1;
    model_kill();
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_in_en", longint'(aes_in_en), 0);
    chkw("kill_aes_data", aes_data, '0);
    chk("kill_frame_err", longint'(frame_err), 0);
    chk("kill_timeout_err", longint'(timeout_err), 0);
    chk("kill_level", longint'(level), 0);
    chk("kill_s_ready", longint'(s_ready), 1);
    @(posedge clk); #1;
    send_block(128'hCAFEF00D_01234567_89ABCDEF_76543210);
    drain();

    // Idle gating.
    idle_force = 1'b1;
    send_block({$urandom, $urandom, $urandom, $urandom});
    r = n_issue;
    repeat (20) begin @(posedge clk); #1; end
    chk("gated_no_issue", n_issue, r);
    idle_force = 1'b0;
    r = cyc;
    wait_issue(at);
    chk("ungate_latency", at, r + 1);
    drain();

    // Random frames with occasional framing errors and random core latency.
    rand_delay = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        int pos = int'($urandom_range(0, 2));
        for (int w = 0; w <= pos; w++) send_word($urandom, w == pos);
      end else if (kind == 1) begin
        for (int w = 0; w < 4; w++) send_word($urandom, 1'b0);
      end else begin
        for (int w = 0; w < 4; w++) begin
          send_word($urandom, w == 3);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    end
    drain();
    chk("final_frame_q_empty", frame_q.size(), 0);
    chk("final_tmo_q_empty", tmo_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
